sb_track_rv_fifo: RTL and testbench
===================================

# sb_track_rv_fifo

Ready/valid buffering stage on one switchbox output track of the sparse-tile interconnect. It sits directly downstream of the fanout ready combiner: its `in_ready` is one of the per-sink ready inputs that the combiner ANDs, and its input handshake is driven by the combiner's `O` and the track's valid. It provides a configurable-depth registered FIFO that breaks the ready path across the switchbox, plus a config-selected combinational bypass.

## Interface
- `DATA_WIDTH`, 17: track payload width (16-bit data plus 1 stop/control bit).
- `DEPTH`, 2: FIFO entries; power of two, ≥2.
- `CNT_W`, $clog2(DEPTH)+1: occupancy counter width (derived, not overridden).

- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `fifo_en`  in  1  static config: 1 = buffered, 0 = bypass.
- `in_data`  in  DATA_WIDTH  upstream payload.
- `in_valid`  in  1  upstream valid.
- `in_ready`  out  1  to fanout ready combiner / upstream.
- `out_data`  out  DATA_WIDTH  downstream payload.
- `out_valid`  out  1  downstream valid.
- `out_ready`  in  1  downstream ready.
- `count`  out  CNT_W  current occupancy (debug/perf).

## Operation
- Push = `in_valid & in_ready`; pop = `out_valid & out_ready`. Transfer only on both high at a rising edge.
- Buffered mode (`fifo_en`=1):
  - `in_ready` = (`count` < DEPTH); no combinational path from `out_ready` to `in_ready` (push refused when full, even with simultaneous pop).
  - `out_valid` = (`count` ≠ 0); `out_data` = `mem[rd_ptr]`, driven from registers.
  - Push: write `mem[wr_ptr]`, `wr_ptr`++ mod DEPTH. Pop: `rd_ptr`++ mod DEPTH.
  - Count: push only +1, pop only −1, both → unchanged (pointers both advance).
  - Strict FIFO order; no data loss or duplication.
- Bypass mode (`fifo_en`=0): `out_data`=`in_data`, `out_valid`=`in_valid`, `in_ready`=`out_ready`, all combinational; `count`, pointers held at 0; storage not written.
- `fifo_en` change at runtime: on the first edge with `fifo_en`=0, pointers and count clear (buffered contents discarded). On 1→0, entries still held are lost by definition; config is changed only while idle.
- Reset: `count`=0, `wr_ptr`=`rd_ptr`=0. `out_valid`=0 and `in_ready`=0 while `reset` is high in both modes; `mem` contents not reset (don't-care, masked by `out_valid`=0).
- Reset mid-transfer: a push/pop coincident with the reset edge is discarded; the FIFO is empty on the next cycle.

## Timing
- Buffered latency: data pushed at edge N is visible on `out_data` with `out_valid`=1 after edge N (cycle N+1); no same-cycle fall-through.
- Throughput: 1 transfer/cycle sustained when DEPTH≥2 and downstream always ready.
- `in_ready` depends only on `count` and `reset` in buffered mode (registered-equivalent timing).
- Bypass: zero latency, purely combinational in→out and out_ready→in_ready.
- After reset deasserts: `in_ready`=1 (buffered) in the first cycle; `out_valid`=0.

## Structure
- Package `sb_rv_pkg`: `DATA_WIDTH` default, `DEPTH` default, count-width function, `track_word_t` typedef (packed struct: 16-bit data, 1-bit stop).
- One sub-module `sb_rv_fifo_mem`: DEPTH×DATA_WIDTH flop array with write enable/address and async read address; control (pointers, count, bypass mux) in the top.

## Test plan
- Reset: assert `reset` 3 cycles with `in_valid`=1 → `in_ready`=0, `out_valid`=0, `count`=0; release → `in_ready`=1 next cycle.
- Fill/drain, DEPTH=2: `out_ready`=0, push 0x00A, 0x00B → `count`=2, `in_ready`=0, third word held; `out_ready`=1 → outputs 0x00A then 0x00B, `count`→0, `out_valid`=0.
- Streaming: `in_valid`=`out_ready`=1, push 0x001..0x010 → output identical order, one per cycle after 1-cycle latency, `count` stays 1.
- Full + simultaneous pop: `count`=2, `in_valid`=1, `out_ready`=1 → pop occurs, push refused (`in_ready`=0), `count`=1 next cycle.
- Bypass: `fifo_en`=0, `in_data`=0x1ABC, `in_valid`=1, toggle `out_ready` → `out_data`=0x1ABC, `out_valid`=1, `in_ready` follows `out_ready` same cycle; `count`=0.
- Reset mid-operation: `count`=2, assert `reset` one cycle during a push → next cycle `count`=0, `out_valid`=0; subsequent push 0x055 emerges first.

Source files
------------

// File: rtl/sb_rv_pkg.sv
// Shared types and defaults for switchbox track ready/valid buffering.
// Track word is 16 data bits plus one stop/control bit.
package sb_rv_pkg;

  localparam int SB_DATA_WIDTH = 17;
  localparam int SB_DEPTH      = 2;

  typedef struct packed {
    logic [15:0] data;
    logic        stop;
  } track_word_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sb_rv_fifo_mem.sv
// Flop-array storage for the track FIFO.
// Registered write port, asynchronous read port, no reset on contents.
module sb_rv_fifo_mem #(
  parameter int DATA_WIDTH = 17,
  parameter int DEPTH      = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // write the addressed entry on an accepted push
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sb_track_rv_fifo.sv
// Switchbox output-track ready/valid stage: registered FIFO or bypass.
// Buffered in_ready depends only on occupancy, breaking the ready path.
module sb_track_rv_fifo
  import sb_rv_pkg::*;
#(
  parameter int DATA_WIDTH = SB_DATA_WIDTH,
  parameter int DEPTH      = SB_DEPTH,
  localparam int CNT_W     = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  push;
  logic                  pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  sb_rv_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (push & fifo_en),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  // handshake and data mux: buffered from registers, bypass straight through
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = in_data;
    if (fifo_en) begin
      in_ready  = ~reset & (count < CNT_W'(DEPTH));
      out_valid = ~reset & (count != '0);
      out_data  = rdata;
    end else begin
      in_ready  = ~reset & out_ready;
      out_valid = ~reset & in_valid;
    end
  end

  // pointers and occupancy; cleared by reset and held at 0 in bypass
  always_ff @(posedge clk) begin
    if (reset || !fifo_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_track_rv_fifo.sv
// Scoreboard bench for sb_track_rv_fifo.
// Queue model of FIFO contents; monitor checks outputs each cycle.
module tb_sb_track_rv_fifo;
  import sb_rv_pkg::*;

  localparam int DW = SB_DATA_WIDTH;
  localparam int D  = SB_DEPTH;
  localparam int CW = cnt_w(D);

  logic          clk;
  logic          reset;
  logic          fifo_en;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;

  int            checks = 0;
  int            fails  = 0;
  logic          done   = 1'b0;
  logic [DW-1:0] expq [$];

  sb_track_rv_fifo dut (
    .clk      (clk),
    .reset    (reset),
    .fifo_en  (fifo_en),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock of stimulus; model commits at the rising edge
  task automatic cycle(input logic r, input logic e, input logic v,
                       input logic [DW-1:0] d, input logic rdy);
    logic acc;
    @(negedge clk);
    reset     = r;
    fifo_en   = e;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    #1;
    if (r)
      check("in_ready_rst", 32'(in_ready), 32'd0);
    else if (e)
      check("in_ready_buf", 32'(in_ready), 32'(expq.size() < D));
    else
      check("in_ready_byp", 32'(in_ready), 32'(rdy));
    acc = !r && e && v && (expq.size() < D);
    @(posedge clk);
    if (r || !e)
      expq.delete();
    else if (acc)
      expq.push_back(d);
  endtask

  // monitor: compare outputs against the model, pop on expected transfer
  always begin
    @(negedge clk);
    #2;
    if (!done) begin
      if (reset) begin
        check("out_valid_rst", 32'(out_valid), 32'd0);
      end else if (!fifo_en) begin
        check("out_valid_byp", 32'(out_valid), 32'(in_valid));
        if (in_valid)
          check("out_data_byp", 32'(out_data), 32'(in_data));
        check("count_byp", 32'(count), 32'd0);
      end else begin
        check("count", 32'(count), 32'(expq.size()));
        check("out_valid", 32'(out_valid), 32'(expq.size() != 0));
        if (expq.size() != 0) begin
          check("out_data", 32'(out_data), 32'(expq[0]));
          if (out_ready)
            void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    track_word_t w;
    reset     = 1'b1;
    fifo_en   = 1'b1;
    in_valid  = 1'b1;
    in_data   = '0;
    out_ready = 1'b0;

    repeat (3) cycle(1, 1, 1, DW'('h1), 0);
    cycle(0, 1, 0, '0, 0);

    cycle(0, 1, 1, DW'('h00A), 0);
    cycle(0, 1, 1, DW'('h00B), 0);
    cycle(0, 1, 1, DW'('h00C), 0);
    repeat (3) cycle(0, 1, 0, '0, 1);

    for (int i = 1; i <= 16; i++)
      cycle(0, 1, 1, DW'(i), 1);
    cycle(0, 1, 0, '0, 1);

    cycle(0, 1, 1, DW'('h021), 0);
    cycle(0, 1, 1, DW'('h022), 0);
    cycle(0, 1, 1, DW'('h023), 1);
    repeat (2) cycle(0, 1, 0, '0, 1);

    for (int i = 0; i < 4; i++)
      cycle(0, 0, 1, DW'('h1ABC), i[0]);
    cycle(0, 0, 0, '0, 1);

    cycle(0, 1, 1, DW'('h031), 0);
    cycle(0, 1, 1, DW'('h032), 0);
    cycle(1, 1, 1, DW'('h033), 1);
    cycle(0, 1, 1, DW'('h055), 0);
    repeat (2) cycle(0, 1, 0, '0, 1);

    for (int i = 0; i < 400; i++) begin
      w.data = 16'($urandom);
      w.stop = 1'($urandom);
      cycle(($urandom_range(0, 49) == 0), 1,
            1'($urandom), DW'(w), 1'($urandom));
    end
    repeat (3) cycle(0, 1, 0, '0, 1);

    done = 1'b1;
    @(negedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
